// File: rtl/shift_frame_arb.sv
// Round-robin arbiter for two parallel requesters feeding a serial shift chain.
// Shifts the granted word out LSB-first while capturing WIDTH serial-input bits.
module shift_frame_arb #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  input  logic             si,
  output logic             so,
  output logic             so_en,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_id,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             grant_id;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] rx_sh;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic             hs;
  logic             hs_id;
  logic [WIDTH-1:0] sel_data;

  // Grant selection: under contention the requester that did not win last time goes.
  always_comb begin
    req_ready = 2'b00;
    if (state == ST_IDLE) begin
      if (req_valid == 2'b11) begin
        req_ready = last_grant ? 2'b01 : 2'b10;
      end else begin
        req_ready = req_valid;
      end
    end else begin
      req_ready = 2'b00;
    end
  end

  assign hs       = |req_ready;
  assign hs_id    = req_ready[1];
  assign sel_data = hs_id ? req_data1 : req_data0;
  assign busy     = (state != ST_IDLE);

  // Frame sequencing, serial shifting and receive capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= 4'd0;
      so         <= 1'b0;
      so_en      <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_id      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hs) begin
            so         <= sel_data[0];
            so_en      <= 1'b1;
            tx_sh      <= sel_data >> 1;
            grant_id   <= hs_id;
            last_grant <= hs_id;
            bit_cnt    <= '0;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // si is sampled on the edge that ends each bit cycle
          rx_sh <= {si, rx_sh[WIDTH-1:1]};
          if (bit_cnt == LAST_BIT) begin
            rx_data  <= {si, rx_sh[WIDTH-1:1]};
            rx_valid <= 1'b1;
            rx_id    <= grant_id;
            so       <= 1'b0;
            so_en    <= 1'b0;
            gap_cnt  <= 4'd0;
            state    <= (GAP == 0) ? ST_IDLE : ST_GAP;
          end else begin
            so      <= tx_sh[0];
            tx_sh   <= tx_sh >> 1;
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_frame_arb.sv
// Directed bench for shift_frame_arb: loopback scoreboard on a GAP=2 instance
// plus handshake/receive timing on a GAP=0 instance.
module tb_shift_frame_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready, g_valid, g_ready;
  logic [7:0] d0, d1, rx_data, g_rx_data;
  logic       so, so_en, rx_valid, rx_id, busy;
  logic       g_so, g_so_en, g_rx_valid, g_rx_id, g_busy;

  always #5 clk = ~clk;

  shift_frame_arb #(.WIDTH(8), .GAP(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(d0), .req_data1(d1),
    .req_ready(req_ready), .si(so), .so(so), .so_en(so_en), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_id(rx_id), .busy(busy)
  );

  shift_frame_arb #(.WIDTH(8), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .req_valid(g_valid), .req_data0(d0), .req_data1(d1),
    .req_ready(g_ready), .si(g_so), .so(g_so), .so_en(g_so_en), .rx_data(g_rx_data),
    .rx_valid(g_rx_valid), .rx_id(g_rx_id), .busy(g_busy)
  );

  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         hs_cyc[$];
  logic       hs_id_q[$];
  int         rx_cyc[$];
  int         ghs_cyc[$];
  int         grx_cyc[$];
  logic [7:0] grx_data[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] pat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return hs_cyc.size();
      1:       return rx_cyc.size();
      2:       return ghs_cyc.size();
      default: return 0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int n, input string tag);
    int i;
    i = 0;
    while (qsize(which) < n && i < 200) begin
      @(negedge clk);
      #4;
      i++;
    end
    check({tag, "_timeout"}, 32'(qsize(which) >= n), 32'd1);
  endtask

  // Monitor: log handshakes and receive pulses, score rx words against expectations.
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      if (|(req_valid & req_ready)) begin
        hs_cyc.push_back(cyc);
        hs_id_q.push_back(req_ready[1]);
      end
      if (|(g_valid & g_ready)) ghs_cyc.push_back(cyc);
      if (g_rx_valid) begin
        grx_cyc.push_back(cyc);
        grx_data.push_back(g_rx_data);
      end
    end
    if (rx_valid) begin
      rx_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("rx_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(mon_e.data));
        check("rx_id", 32'(rx_id), 32'(mon_e.id));
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = 2'b00; g_valid = 2'b00; d0 = 8'h00; d1 = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_so", 32'(so), 32'd0);
    check("rst_so_en", 32'(so_en), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_id", 32'(rx_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single frame A5 from requester 0; data changed mid-frame must not matter
    @(negedge clk);
    d0 = 8'hA5; req_valid = 2'b01; pat = 8'hA5;
    #1;
    check("t1_ready", 32'(req_ready), 32'd1);
    exp_q.push_back({1'b0, 8'hA5});
    @(negedge clk);
    req_valid = 2'b11; d0 = 8'h00; d1 = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("t1_so", 32'(so), 32'(pat[k]));
      check("t1_so_en", 32'(so_en), 32'd1);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_ready_shift", 32'(req_ready), 32'd0);
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      if (j == 1) req_valid = 2'b00;
      #1;
      check("t1_so_gap", 32'(so), 32'd0);
      check("t1_so_en_gap", 32'(so_en), 32'd0);
      check("t1_busy_gap", 32'(busy), 32'd1);
      check("t1_ready_gap", 32'(req_ready), 32'd0);
      check("t1_rx_valid", 32'(rx_valid), (j == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    #1;
    check("t1_busy_idle", 32'(busy), 32'd0);
    check("t1_hs_count", 32'(hs_cyc.size()), 32'd1);
    check("t1_rx_count", 32'(rx_cyc.size()), 32'd1);
    if (hs_cyc.size() == 1 && rx_cyc.size() == 1)
      check("t1_rx_latency", 32'(rx_cyc[0] - hs_cyc[0]), 32'd9);

    // Lone requester 1 with 3C: three back-to-back frames
    hs_cyc.delete(); hs_id_q.delete(); rx_cyc.delete();
    @(negedge clk);
    d1 = 8'h3C; req_valid = 2'b10;
    repeat (3) exp_q.push_back({1'b1, 8'h3C});
    wait_for(0, 3, "lone_hs");
    @(negedge clk);
    req_valid = 2'b00;
    wait_for(1, 3, "lone_rx");
    if (hs_cyc.size() == 3 && rx_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) check("lone_id", 32'(hs_id_q[i]), 32'd1);
      for (int i = 1; i < 3; i++) check("lone_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd11);
      check("lone_rx_latency", 32'(rx_cyc[0] - hs_cyc[0]), 32'd9);
    end

    // Contention from reset release: grants 0,1,0,1 every 11 cycles
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    hs_cyc.delete(); hs_id_q.delete(); rx_cyc.delete();
    rst = 1'b0; d0 = 8'h96; d1 = 8'h69; req_valid = 2'b11;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, 8'h96});
      exp_q.push_back({1'b1, 8'h69});
    end
    wait_for(0, 4, "cont_hs");
    @(negedge clk);
    req_valid = 2'b00;
    wait_for(1, 4, "cont_rx");
    if (hs_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) check("cont_id", 32'(hs_id_q[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) check("cont_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd11);
    end

    // Reset at bit 4 of a requester-0 frame, then contention must favour 0
    repeat (4) @(negedge clk);
    hs_cyc.delete(); hs_id_q.delete();
    d0 = 8'hFF; req_valid = 2'b01;
    #4;
    check("rm_hs", 32'(hs_cyc.size()), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rm_so_en_mid", 32'(so_en), 32'd1);
    @(negedge clk);
    rst = 1'b0; d0 = 8'hC3; req_valid = 2'b11;
    hs_cyc.delete(); hs_id_q.delete();
    exp_q.push_back({1'b0, 8'hC3});
    #1;
    check("rm_so", 32'(so), 32'd0);
    check("rm_so_en", 32'(so_en), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_rx_valid", 32'(rx_valid), 32'd0);
    check("rm_ready", 32'(req_ready), 32'd1);
    wait_for(0, 1, "rm_hs2");
    @(negedge clk);
    req_valid = 2'b00;
    if (hs_id_q.size() == 1) check("rm_first_id", 32'(hs_id_q[0]), 32'd0);
    repeat (12) @(negedge clk);

    // GAP=0 instance: next grant one cycle after the frame, coinciding with rx_valid
    ghs_cyc.delete(); grx_cyc.delete(); grx_data.delete();
    g_valid = 2'b11;
    wait_for(2, 3, "g0_hs");
    @(negedge clk);
    g_valid = 2'b00;
    if (ghs_cyc.size() == 3 && grx_cyc.size() >= 2) begin
      check("g0_spacing1", 32'(ghs_cyc[1] - ghs_cyc[0]), 32'd9);
      check("g0_spacing2", 32'(ghs_cyc[2] - ghs_cyc[1]), 32'd9);
      check("g0_rx_at_hs", 32'(grx_cyc[0]), 32'(ghs_cyc[1]));
      check("g0_rx_data0", 32'(grx_data[0]), 32'hC3);
      check("g0_rx_data1", 32'(grx_data[1]), 32'h69);
    end else begin
      check("g0_counts", 32'(ghs_cyc.size()), 32'd3);
    end
    repeat (12) @(negedge clk);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
